spi_driver: RTL and testbench



---
 rtl/spi_driver_if.sv | 31 +++
 rtl/spi_driver.sv | 185 ++++++++++++++++++
 tb/tb_spi_driver.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_driver_if.sv
// Command and serial-pin bundle for spi_driver.
// master = the SPI driver itself; slave = control logic plus chip pins.
interface spi_driver_if;
    logic       new_command;
    logic [7:0] write_register_addr;
    logic [7:0] write_data;
    logic [7:0] num_regs_to_read;
    logic [7:0] start_read_register_addr;
    logic       is_write;
    logic       serial_in;
    logic       serial_out;
    logic       spi_clk;
    logic [7:0] data_read_from_reg;
    logic       write_complete;
    logic       read_complete;
    logic       fifo_wr_en;

    modport master (
        input  new_command, write_register_addr, write_data, num_regs_to_read,
               start_read_register_addr, is_write, serial_in,
        output serial_out, spi_clk, data_read_from_reg, write_complete,
               read_complete, fifo_wr_en
    );

    modport slave (
        output new_command, write_register_addr, write_data, num_regs_to_read,
               start_read_register_addr, is_write, serial_in,
        input  serial_out, spi_clk, data_read_from_reg, write_complete,
               read_complete, fifo_wr_en
    );
endinterface

// File: rtl/spi_driver.sv
// SPI master issuing register writes and burst reads (spi_clk = clk/2, MSB first).
// Burst-read path is built only when SPI_DRIVER_READ_EN is defined.
module spi_driver (
    input  logic         clk,
    input  logic         rstn,
    spi_driver_if.master bus
);

    typedef enum logic [2:0] {IDLE, TX_HEADER, TX_DATA, RX_DATA, DONE} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_cmd_prev;
    logic       r_start;
    logic       r_is_write;
    logic [7:0] r_header;
    logic [7:0] r_wdata;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_spi_clk;
    logic       r_serial_out;
    logic       r_write_complete;
    logic       r_read_complete;
    logic       w_accept;
    logic       w_byte_end;
    logic       w_unused;
`ifdef SPI_DRIVER_READ_EN
    logic [7:0] r_num_regs;
    logic [7:0] r_byte_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_data_read;
    logic       r_fifo_wr_en;
`endif

    // A byte ends on the clk edge that takes spi_clk high->low after its 8th bit.
    assign w_byte_end = r_spi_clk && (r_bit_cnt == 3'd7);

`ifdef SPI_DRIVER_READ_EN
    assign w_accept = (r_state == IDLE) && bus.new_command && !r_cmd_prev;
    assign w_unused = &{1'b0, bus.write_register_addr[7], bus.start_read_register_addr[7]};
`else
    assign w_accept = (r_state == IDLE) && bus.new_command && !r_cmd_prev && bus.is_write;
    assign w_unused = &{1'b0, bus.write_register_addr[7], bus.start_read_register_addr[7],
                        bus.serial_in, bus.num_regs_to_read};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (r_start) w_next_state = TX_HEADER;
            end
            TX_HEADER: begin
                if (w_byte_end) begin
                    if (r_is_write) w_next_state = TX_DATA;
`ifdef SPI_DRIVER_READ_EN
                    else if (r_num_regs == 8'd0) w_next_state = DONE;
                    else w_next_state = RX_DATA;
`else
                    else w_next_state = DONE;
`endif
                end
            end
            TX_DATA: begin
                if (w_byte_end) w_next_state = DONE;
            end
            RX_DATA: begin
`ifdef SPI_DRIVER_READ_EN
                if (w_byte_end && (r_byte_cnt == r_num_regs - 8'd1)) w_next_state = DONE;
`else
                w_next_state = IDLE;
`endif
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // r_shift holds the bits still to send after the one on serial_out, so it
    // drains to zero and serial_out falls to 0 by itself once a byte is done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmd_prev       <= 1'b0;
            r_start          <= 1'b0;
            r_is_write       <= 1'b0;
            r_header         <= '0;
            r_wdata          <= '0;
            r_shift          <= '0;
            r_bit_cnt        <= '0;
            r_spi_clk        <= 1'b0;
            r_serial_out     <= 1'b0;
            r_write_complete <= 1'b0;
            r_read_complete  <= 1'b0;
`ifdef SPI_DRIVER_READ_EN
            r_num_regs       <= '0;
            r_byte_cnt       <= '0;
            r_rx_shift       <= '0;
            r_data_read      <= '0;
            r_fifo_wr_en     <= 1'b0;
`endif
        end else begin
            r_cmd_prev       <= bus.new_command;
            r_start          <= w_accept;
            r_write_complete <= 1'b0;
            r_read_complete  <= 1'b0;
`ifdef SPI_DRIVER_READ_EN
            r_fifo_wr_en     <= 1'b0;
`endif
            if (w_accept) begin
                r_is_write <= bus.is_write;
                r_header   <= bus.is_write ? {1'b0, bus.write_register_addr[6:0]}
                                           : {1'b1, bus.start_read_register_addr[6:0]};
                r_wdata    <= bus.write_data;
`ifdef SPI_DRIVER_READ_EN
                r_num_regs <= bus.num_regs_to_read;
`endif
            end

            case (r_state)
                IDLE: begin
                    if (r_start) begin
                        r_serial_out <= r_header[7];
                        r_shift      <= {r_header[6:0], 1'b0};
                        r_bit_cnt    <= 3'd0;
                        r_spi_clk    <= 1'b0;
`ifdef SPI_DRIVER_READ_EN
                        r_byte_cnt   <= '0;
`endif
                    end
                end
                TX_HEADER, TX_DATA, RX_DATA: begin
                    r_spi_clk <= ~r_spi_clk;
                    if (r_spi_clk) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if ((r_state == TX_HEADER) && (w_next_state == TX_DATA)) begin
                            r_serial_out <= r_wdata[7];
                            r_shift      <= {r_wdata[6:0], 1'b0};
                        end else begin
                            r_serial_out <= r_shift[7];
                            r_shift      <= {r_shift[6:0], 1'b0};
                        end
`ifdef SPI_DRIVER_READ_EN
                        if (r_state == RX_DATA) begin
                            r_rx_shift <= {r_rx_shift[6:0], bus.serial_in};
                            if (r_bit_cnt == 3'd7) begin
                                r_data_read  <= {r_rx_shift[6:0], bus.serial_in};
                                r_fifo_wr_en <= 1'b1;
                                r_byte_cnt   <= r_byte_cnt + 8'd1;
                            end
                        end
`endif
                    end
                end
                DONE: begin
                    r_spi_clk        <= 1'b0;
                    r_serial_out     <= 1'b0;
                    r_write_complete <= r_is_write;
                    r_read_complete  <= !r_is_write;
                end
                default: ;
            endcase
        end
    end

    assign bus.serial_out     = r_serial_out;
    assign bus.spi_clk        = r_spi_clk;
    assign bus.write_complete = r_write_complete;
    assign bus.read_complete  = r_read_complete;
`ifdef SPI_DRIVER_READ_EN
    assign bus.data_read_from_reg = r_data_read;
    assign bus.fifo_wr_en         = r_fifo_wr_en;
`else
    assign bus.data_read_from_reg = 8'd0;
    assign bus.fifo_wr_en         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_driver.sv
// Self-checking bench for spi_driver: cycle-timeline reference model plus a register-file peripheral.
// Expectations follow SPI_DRIVER_READ_EN (reads ignored when undefined).
module tb_spi_driver;

`ifdef SPI_DRIVER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    spi_driver_if bus ();

    spi_driver dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit checking = 1'b0;

    // Reference model of the transaction in flight, as a timeline relative to T0.
    bit         mActive = 1'b0;
    bit         mIsWr   = 1'b1;
    int         mT0     = 0;
    int         mN      = 0;
    int         mTxBits = 16;
    logic [15:0] mFrame = '0;
    logic [7:0] mBytes[$];
    logic [7:0] mLastData = '0;
    logic [7:0] regMem[128];

    int         riseCnt = 0;
    logic [7:0] capHdr  = '0;
    logic [7:0] capData = '0;
    int         fifoCnt = 0;
    int         wcCnt   = 0;
    int         rcCnt   = 0;
    int         wcK     = -1;
    int         rcK     = -1;
    logic [7:0] gotData[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Peripheral view: sample serial_out on spi_clk rises, return registers on falls.
    always @(posedge bus.spi_clk) begin
        if (riseCnt < 8) capHdr = {capHdr[6:0], bus.serial_out};
        else if (riseCnt < 16) capData = {capData[6:0], bus.serial_out};
        riseCnt++;
    end

    always @(negedge bus.spi_clk) begin : periph
        int idx;
        logic [7:0] b;
        if (rstn && !mIsWr) begin
            idx = riseCnt - 8;
            if (idx >= 0 && idx < 8 * mN) begin
                b = mBytes[idx / 8];
                #1 bus.serial_in = b[7 - (idx % 8)];
            end
        end
    end

    always @(negedge clk) begin : compare
        int k, nbits, endK, bi;
        logic eClk, eSo, eFifo, eWc, eRc;
        if (checking) begin
            eClk = 1'b0; eSo = 1'b0; eFifo = 1'b0; eWc = 1'b0; eRc = 1'b0;
            k = cyc - mT0;
            if (!rstn) begin
                mActive   = 1'b0;
                mLastData = '0;
            end else if (mActive) begin
                nbits = mIsWr ? 16 : 8 + 8 * mN;
                endK  = mIsWr ? 34 : 18 + 16 * mN;
                if (k >= 1 && k < 1 + 2 * nbits) begin
                    bi   = (k - 1) / 2;
                    eClk = ((k - 1) % 2) == 1;
                    if (bi < mTxBits) eSo = mFrame[mTxBits - 1 - bi];
                end
                if (!mIsWr && k >= 33 && k <= endK && ((k - 17) % 16) == 0) begin
                    eFifo     = 1'b1;
                    mLastData = mBytes[(k - 17) / 16 - 1];
                end
                eWc = mIsWr && (k == endK);
                eRc = !mIsWr && (k == endK);
                if (k >= endK) mActive = 1'b0;
            end
            checkOutput("spi_clk", 32'(bus.spi_clk), 32'(eClk));
            checkOutput("serial_out", 32'(bus.serial_out), 32'(eSo));
            checkOutput("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(eFifo));
            checkOutput("data_read", 32'(bus.data_read_from_reg), 32'(mLastData));
            checkOutput("write_complete", 32'(bus.write_complete), 32'(eWc));
            checkOutput("read_complete", 32'(bus.read_complete), 32'(eRc));
            if (bus.fifo_wr_en) begin
                fifoCnt++;
                gotData.push_back(bus.data_read_from_reg);
            end
            if (bus.write_complete) begin
                wcCnt++;
                wcK = k;
            end
            if (bus.read_complete) begin
                rcCnt++;
                rcK = k;
            end
        end
    end

    task automatic applyStimulus(input bit isWr, input logic [7:0] addr,
                                 input logic [7:0] wd, input int n);
        @(posedge clk);
        #1;
        bus.is_write                 = isWr;
        bus.write_register_addr      = addr;
        bus.start_read_register_addr = addr;
        bus.write_data               = wd;
        bus.num_regs_to_read         = 8'(n);
        bus.new_command              = 1'b1;
        riseCnt = 0; capHdr = '0; capData = '0;
        fifoCnt = 0; wcCnt = 0; rcCnt = 0; wcK = -1; rcK = -1;
        gotData.delete();
        mIsWr   = isWr;
        mN      = isWr ? 0 : n;
        mT0     = cyc + 1;
        mTxBits = isWr ? 16 : 8;
        mFrame  = isWr ? {1'b0, addr[6:0], wd} : {8'h00, 1'b1, addr[6:0]};
        mBytes.delete();
        for (int m = 0; m < mN; m++) mBytes.push_back(regMem[(int'(addr[6:0]) + m) % 128]);
        mActive = isWr || READ_EN;
        @(posedge clk);
        #1;
        bus.is_write                 = 1'($urandom);
        bus.write_register_addr      = 8'($urandom);
        bus.start_read_register_addr = 8'($urandom);
        bus.write_data               = 8'($urandom);
        bus.num_regs_to_read         = 8'($urandom);
        @(posedge clk);
        #1;
        bus.new_command = 1'b0;
    endtask

    task automatic waitIdle();
        int i = 0;
        while (mActive && i < 3000) begin
            @(posedge clk);
            i++;
        end
        checkOutput("txn_finished", 32'(mActive), 32'(0));
        repeat (3) @(posedge clk);
    endtask

    task automatic checkTxn(input bit isWr, input logic [7:0] addr,
                            input logic [7:0] wd, input int n);
        bit rd;
        rd = !isWr && READ_EN;
        checkOutput("rises", riseCnt, isWr ? 16 : (READ_EN ? 8 + 8 * n : 0));
        checkOutput("header", 32'(capHdr),
                    isWr ? 32'({1'b0, addr[6:0]}) : (READ_EN ? 32'({1'b1, addr[6:0]}) : 32'(0)));
        checkOutput("wdata", 32'(capData), isWr ? 32'(wd) : 32'(0));
        checkOutput("wc_count", wcCnt, isWr ? 1 : 0);
        checkOutput("rc_count", rcCnt, rd ? 1 : 0);
        checkOutput("fifo_count", fifoCnt, rd ? n : 0);
        for (int i = 0; i < gotData.size() && i < mBytes.size(); i++)
            checkOutput("rd_byte", 32'(gotData[i]), 32'(mBytes[i]));
    endtask

    initial begin
        bus.new_command = 1'b0;
        bus.write_register_addr = '0;
        bus.write_data = '0;
        bus.num_regs_to_read = '0;
        bus.start_read_register_addr = '0;
        bus.is_write = 1'b0;
        bus.serial_in = 1'b0;
        for (int i = 0; i < 128; i++) regMem[i] = 8'($urandom);

        #2 rstn = 1'b0;
        #1;
        checkOutput("rst_spi_clk", 32'(bus.spi_clk), 32'(0));
        checkOutput("rst_serial_out", 32'(bus.serial_out), 32'(0));
        checkOutput("rst_data", 32'(bus.data_read_from_reg), 32'(0));
        checkOutput("rst_wc", 32'(bus.write_complete), 32'(0));
        checkOutput("rst_rc", 32'(bus.read_complete), 32'(0));
        checkOutput("rst_fifo", 32'(bus.fifo_wr_en), 32'(0));
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        checking = 1'b1;

        $display("[TB] write 0x01 <- 0xF0");
        applyStimulus(1'b1, 8'h01, 8'hF0, 0);
        waitIdle();
        checkTxn(1'b1, 8'h01, 8'hF0, 0);
        checkOutput("w1_frame", {16'h0, capHdr, capData}, 32'h0000_01F0);
        checkOutput("w1_wc_time", wcK, 34);

        $display("[TB] back-to-back writes to 0x02");
        applyStimulus(1'b1, 8'h02, 8'h03, 0);
        waitIdle();
        checkTxn(1'b1, 8'h02, 8'h03, 0);
        repeat (7) @(posedge clk);
        applyStimulus(1'b1, 8'h02, 8'h02, 0);
        waitIdle();
        checkTxn(1'b1, 8'h02, 8'h02, 0);
        checkOutput("w3_frame", {16'h0, capHdr, capData}, 32'h0000_0202);

        $display("[TB] burst read 0x04 N=7");
        for (int i = 0; i < 7; i++) regMem[4 + i] = 8'(8'hA0 + i);
        applyStimulus(1'b0, 8'h04, 8'h00, 7);
        waitIdle();
        checkTxn(1'b0, 8'h04, 8'h00, 7);
        checkOutput("r7_header", 32'(capHdr), READ_EN ? 32'h84 : 32'h0);
        checkOutput("r7_rc_time", rcK, READ_EN ? 130 : -1);
        checkOutput("r7_nbytes", gotData.size(), READ_EN ? 7 : 0);
        for (int i = 0; i < gotData.size(); i++)
            checkOutput("r7_byte", 32'(gotData[i]), 32'(160 + i));

        $display("[TB] read N=0");
        applyStimulus(1'b0, 8'h15, 8'h00, 0);
        waitIdle();
        repeat (30) @(posedge clk);
        checkTxn(1'b0, 8'h15, 8'h00, 0);
        checkOutput("r0_header", 32'(capHdr), READ_EN ? 32'h95 : 32'h0);
        checkOutput("r0_rc_time", rcK, READ_EN ? 18 : -1);

        $display("[TB] new_command toggled mid-write");
        applyStimulus(1'b1, 8'h33, 8'hC5, 0);
        repeat (8) @(posedge clk);
        #1;
        bus.new_command = 1'b1;
        bus.is_write = 1'b0;
        bus.write_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 bus.new_command = 1'b0;
        waitIdle();
        checkTxn(1'b1, 8'h33, 8'hC5, 0);

        $display("[TB] reset during read");
        applyStimulus(1'b0, 8'h10, 8'h00, 3);
        repeat (40) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        checkOutput("midrst_spi_clk", 32'(bus.spi_clk), 32'(0));
        checkOutput("midrst_serial_out", 32'(bus.serial_out), 32'(0));
        checkOutput("midrst_data", 32'(bus.data_read_from_reg), 32'(0));
        checkOutput("midrst_fifo", 32'(bus.fifo_wr_en), 32'(0));
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        repeat (80) @(posedge clk);
        checkOutput("midrst_no_rc", rcCnt, 0);
        applyStimulus(1'b1, 8'h7F, 8'h5A, 0);
        waitIdle();
        checkTxn(1'b1, 8'h7F, 8'h5A, 0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 12; t++) begin
            bit isWr;
            logic [7:0] addr, wd;
            int n;
            isWr = 1'($urandom_range(0, 1));
            addr = 8'($urandom);
            wd   = 8'($urandom);
            n    = $urandom_range(0, 4);
            applyStimulus(isWr, addr, wd, n);
            waitIdle();
            if (!isWr) repeat (30) @(posedge clk);
            checkTxn(isWr, addr, wd, n);
            repeat ($urandom_range(1, 10)) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
